// File: rtl/wb_arbiter_2.sv
// Two-master, one-slave Wishbone arbiter with round-robin tie-break, grant held
// for a whole cyc, and a strobe-without-ack watchdog that aborts hung transfers.
module wb_arbiter_2 #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  output logic [1:0]  grant,
  output logic [1:0]  state_dbg
);

  // Handshake: a beat is a cycle where cyc & stb are high; it completes on the
  // cycle the slave returns ack (or the watchdog returns err instead).

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t          state;
  logic            last;
  logic [CW-1:0]   cnt;
  logic [1:0]      grant_q;

  logic            owner1;
  logic            own_cyc;
  logic            own_stb;
  logic            owned;
  logic            timeout_hit;

  // The grant register names the owner in both OWNn and ABORT.
  assign owner1  = grant_q[1];
  assign own_cyc = owner1 ? m1_cyc : m0_cyc;
  assign own_stb = owner1 ? m1_stb : m0_stb;
  assign owned   = !reset && ((state == OWN0) || (state == OWN1));

  assign timeout_hit = (TIMEOUT > 0) && owned && own_cyc && own_stb && !s_ack &&
                       (cnt == LIMIT);

  always_comb begin
    s_cyc     = owned && own_cyc;
    s_stb     = owned && own_stb;
    s_we      = owned && (owner1 ? m1_we : m0_we);
    s_addr    = owned ? (owner1 ? m1_addr : m0_addr) : 32'h0;
    s_wdata   = owned ? (owner1 ? m1_wdata : m0_wdata) : 32'h0;
    m0_ack    = owned && !owner1 && s_ack;
    m1_ack    = owned && owner1 && s_ack;
    m0_err    = timeout_hit && !owner1;
    m1_err    = timeout_hit && owner1;
    m0_rdata  = s_rdata;
    m1_rdata  = s_rdata;
    grant     = reset ? 2'b00 : grant_q;
    state_dbg = state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      cnt     <= '0;
      grant_q <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          // last only moves on a genuine tie, so a lone requester never
          // steals the next tie from the other master.
          if (m0_cyc && (!m1_cyc || last)) begin
            state   <= OWN0;
            grant_q <= 2'b01;
            if (m1_cyc) last <= 1'b0;
          end else if (m1_cyc) begin
            state   <= OWN1;
            grant_q <= 2'b10;
            if (m0_cyc) last <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (!own_cyc) begin
            state   <= IDLE;
            grant_q <= 2'b00;
            cnt     <= '0;
          end else if (timeout_hit) begin
            state <= ABORT;
            cnt   <= '0;
          end else if (s_ack || !own_stb || (TIMEOUT == 0)) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ABORT: begin
          cnt <= '0;
          if (!own_cyc) begin
            state   <= IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= 2'b00;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2.sv
// Directed bench for wb_arbiter_2 (TIMEOUT=8): one task per scenario, inline
// checks against hand-computed values, single summary line at the end.
module tb_wb_arbiter_2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN0  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_ack;
  logic [1:0]  grant, state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter_2 #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack),
    .grant(grant), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "simulation time limit");
  end

  // Driver tasks
  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    s_rdata = '0; s_ack = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    step_clk();
    step_clk();
    @(negedge clock);
    n_checks++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL rst_s_cyc: got %b expected 0", s_cyc); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b expected 00", grant); end
    step_clk();
    reset = 0;
    @(negedge clock);
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    n_checks++; if (s_addr !== 32'h0 || s_stb !== 1'b0 || m0_ack !== 1'b0 || m0_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_outputs: got addr=%h stb=%b ack=%b err=%b expected 0", s_addr, s_stb, m0_ack, m0_err);
    end
  endtask

  task automatic test_single_write();
    step_clk();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hCAFE0001;
    @(negedge clock);
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL sw_latency: got %b expected 00", grant); end
    step_clk();
    @(negedge clock);
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL sw_grant: got %b expected 01", grant); end
    n_checks++; if (s_addr !== 32'h10 || s_we !== 1'b1 || s_wdata !== 32'hCAFE0001 || s_cyc !== 1'b1) begin
      n_fail++; $display("FAIL sw_bus: got addr=%h we=%b wdata=%h cyc=%b expected 10/1/cafe0001/1", s_addr, s_we, s_wdata, s_cyc);
    end
    n_checks++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL sw_early_ack: got %b expected 0", m0_ack); end
    step_clk();
    s_ack = 1;
    @(negedge clock);
    n_checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      n_fail++; $display("FAIL sw_ack: got m0=%b m1=%b expected 1/0", m0_ack, m1_ack);
    end
    step_clk();
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
    @(negedge clock);
    n_checks++; if (m0_ack !== 1'b0 || s_cyc !== 1'b0) begin
      n_fail++; $display("FAIL sw_release: got ack=%b cyc=%b expected 0/0", m0_ack, s_cyc);
    end
    step_clk();
    @(negedge clock);
    n_checks++; if (grant !== 2'b00 || state_dbg !== ST_IDLE) begin
      n_fail++; $display("FAIL sw_idle: got grant=%b state=%0d expected 00/0", grant, state_dbg);
    end
    step_clk();
    s_ack = 1;
    @(negedge clock);
    n_checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      n_fail++; $display("FAIL late_ack: got m0=%b m1=%b expected 0/0", m0_ack, m1_ack);
    end
    step_clk();
    s_ack = 0;
  endtask

  task automatic test_round_robin();
    reset = 1;
    step_clk();
    reset = 0;
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h200;
    step_clk();
    @(negedge clock);
    n_checks++; if (grant !== 2'b01 || s_addr !== 32'h100) begin
      n_fail++; $display("FAIL rr_first: got grant=%b addr=%h expected 01/100", grant, s_addr);
    end
    step_clk();
    s_ack = 1;
    @(negedge clock);
    n_checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      n_fail++; $display("FAIL rr_ack0: got m0=%b m1=%b expected 1/0", m0_ack, m1_ack);
    end
    step_clk();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    step_clk();
    m0_cyc = 1; m0_stb = 1;
    @(negedge clock);
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rr_dead_cycle: got %b expected 00", grant); end
    step_clk();
    @(negedge clock);
    n_checks++; if (grant !== 2'b10 || s_addr !== 32'h200) begin
      n_fail++; $display("FAIL rr_second: got grant=%b addr=%h expected 10/200", grant, s_addr);
    end
    step_clk();
    s_ack = 1;
    @(negedge clock);
    n_checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      n_fail++; $display("FAIL rr_ack1: got m1=%b m0=%b expected 1/0", m1_ack, m0_ack);
    end
    step_clk();
    clear_inputs();
    step_clk();
  endtask

  task automatic test_burst_hold();
    logic [31:0] beat_data [3];
    int acks;
    beat_data[0] = 32'hA; beat_data[1] = 32'hB; beat_data[2] = 32'hC;
    acks = 0;
    step_clk();
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 32'h300;
    step_clk();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h400;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      s_ack = 1; s_rdata = beat_data[i];
      @(negedge clock);
      if (m1_ack === 1'b1) acks++;
      n_checks++; if (m1_rdata !== beat_data[i] || m0_ack !== 1'b0 || grant !== 2'b10) begin
        n_fail++; $display("FAIL burst_beat%0d: got rdata=%h m0_ack=%b grant=%b expected %h/0/10", i, m1_rdata, m0_ack, grant, beat_data[i]);
      end
    end
    step_clk();
    s_ack = 0;
    @(negedge clock);
    n_checks++; if (acks != 3) begin n_fail++; $display("FAIL burst_acks: got %0d expected 3", acks); end
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL burst_hold: got %b expected 10", grant); end
    step_clk();
    m1_cyc = 0; m1_stb = 0;
    step_clk();
    @(negedge clock);
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL burst_dead: got %b expected 00", grant); end
    step_clk();
    @(negedge clock);
    n_checks++; if (grant !== 2'b01 || s_addr !== 32'h400) begin
      n_fail++; $display("FAIL burst_handover: got grant=%b addr=%h expected 01/400", grant, s_addr);
    end
    step_clk();
    s_ack = 1;
    step_clk();
    clear_inputs();
    step_clk();
  endtask

  task automatic test_timeout();
    step_clk();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h40;
    for (int k = 1; k <= 8; k++) begin
      step_clk();
      if (k == 1) begin
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h50;
      end
      @(negedge clock);
      n_checks++; if (m0_err !== (k == 8) || m0_ack !== 1'b0 || s_cyc !== 1'b1) begin
        n_fail++; $display("FAIL to_stb%0d: got err=%b ack=%b cyc=%b expected %b/0/1", k, m0_err, m0_ack, s_cyc, (k == 8));
      end
    end
    step_clk();
    @(negedge clock);
    n_checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0 || grant !== 2'b01 || state_dbg !== ST_ABORT) begin
      n_fail++; $display("FAIL to_abort: got cyc=%b stb=%b grant=%b state=%0d expected 0/0/01/3", s_cyc, s_stb, grant, state_dbg);
    end
    n_checks++; if (m0_err !== 1'b0 || m1_err !== 1'b0) begin
      n_fail++; $display("FAIL to_err_pulse: got m0=%b m1=%b expected 0/0", m0_err, m1_err);
    end
    step_clk();
    @(negedge clock);
    n_checks++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL to_abort_hold: got %b expected 0", s_cyc); end
    step_clk();
    m0_cyc = 0; m0_stb = 0;
    step_clk();
    @(negedge clock);
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL to_idle: got %b expected 00", grant); end
    step_clk();
    @(negedge clock);
    n_checks++; if (grant !== 2'b10 || s_addr !== 32'h50) begin
      n_fail++; $display("FAIL to_m1_grant: got grant=%b addr=%h expected 10/50", grant, s_addr);
    end
    step_clk();
    s_ack = 1;
    @(negedge clock);
    n_checks++; if (m1_ack !== 1'b1) begin n_fail++; $display("FAIL to_m1_ack: got %b expected 1", m1_ack); end
    step_clk();
    clear_inputs();
    step_clk();
  endtask

  task automatic test_ack_at_limit();
    step_clk();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h80;
    for (int k = 1; k <= 8; k++) begin
      step_clk();
      s_ack = (k == 8);
      @(negedge clock);
      n_checks++; if (m0_err !== 1'b0 || m0_ack !== (k == 8)) begin
        n_fail++; $display("FAIL lim_stb%0d: got err=%b ack=%b expected 0/%b", k, m0_err, m0_ack, (k == 8));
      end
    end
    step_clk();
    s_ack = 0;
    @(negedge clock);
    n_checks++; if (state_dbg !== ST_OWN0 || s_cyc !== 1'b1) begin
      n_fail++; $display("FAIL lim_no_abort: got state=%0d cyc=%b expected 1/1", state_dbg, s_cyc);
    end
    step_clk();
    clear_inputs();
    step_clk();
    @(negedge clock);
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL lim_idle: got %0d expected 0", state_dbg); end
  endtask

  task automatic test_reset_mid();
    step_clk();
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h60;
    step_clk();
    @(negedge clock);
    n_checks++; if (grant !== 2'b10 || s_cyc !== 1'b1) begin
      n_fail++; $display("FAIL rm_owned: got grant=%b cyc=%b expected 10/1", grant, s_cyc);
    end
    step_clk();
    reset = 1;
    @(negedge clock);
    n_checks++; if (s_cyc !== 1'b0 || grant !== 2'b00) begin
      n_fail++; $display("FAIL rm_drop: got cyc=%b grant=%b expected 0/00", s_cyc, grant);
    end
    step_clk();
    reset = 0;
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h70;
    @(negedge clock);
    n_checks++; if (s_cyc !== 1'b0 || grant !== 2'b00 || state_dbg !== ST_IDLE) begin
      n_fail++; $display("FAIL rm_after: got cyc=%b grant=%b state=%0d expected 0/00/0", s_cyc, grant, state_dbg);
    end
    step_clk();
    @(negedge clock);
    n_checks++; if (grant !== 2'b01 || s_addr !== 32'h70) begin
      n_fail++; $display("FAIL rm_tie: got grant=%b addr=%h expected 01/70", grant, s_addr);
    end
    step_clk();
    clear_inputs();
    step_clk();
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_burst_hold();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
